// File: rtl/cpu4_alu_mc_if.sv
// Operand/result channel of the multi-cycle cpu4 ALU: valid/ready in, valid/ready out.
interface cpu4_alu_mc_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             busy;

  modport master (output in_valid, op, a, b, out_ready,
                  input  in_ready, out_valid, y, zero, busy);
  modport slave  (input  in_valid, op, a, b, out_ready,
                  output in_ready, out_valid, y, zero, busy);
endinterface

// File: rtl/cpu4_alu_mc.sv
// Multi-cycle cpu4 EX-stage ALU: single-cycle logic/arith/shift ops plus
// iterative shift-add multiply and restoring unsigned divide/remainder.
module cpu4_alu_mc #(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  cpu4_alu_mc_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND = 4'b0010,
                         OP_OR   = 4'b0011, OP_XOR  = 4'b0100, OP_SLT = 4'b0101,
                         OP_SLTU = 4'b0110, OP_SLL  = 4'b0111, OP_SRL = 4'b1000,
                         OP_SRA  = 4'b1001, OP_MUL  = 4'b1010, OP_DIVU = 4'b1011,
                         OP_REMU = 4'b1100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] acc, sh, opnd, y_r;
  logic             zero_r;
  logic [CW-1:0]    cnt;

  logic             accept, is_iter;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] acc_nxt, sh_nxt, opnd_nxt, iter_y;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == BUSY);
  assign bus.y         = y_r;
  assign bus.zero      = zero_r;

  assign accept  = bus.in_valid && bus.in_ready;
  assign is_iter = MULDIV_EN && ((bus.op == OP_MUL) || (bus.op == OP_DIVU) || (bus.op == OP_REMU));
  assign shamt   = bus.b[SHW-1:0];

  // Single-cycle result; MUL/DIVU/REMU land here only when MULDIV_EN=0 and read as undefined.
  always_comb begin
    alu_y = '0;
    unique case (bus.op)
      OP_ADD:  alu_y = bus.a + bus.b;
      OP_SUB:  alu_y = bus.a - bus.b;
      OP_AND:  alu_y = bus.a & bus.b;
      OP_OR:   alu_y = bus.a | bus.b;
      OP_XOR:  alu_y = bus.a ^ bus.b;
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      OP_SLL:  alu_y = bus.a << shamt;
      OP_SRL:  alu_y = bus.a >> shamt;
      OP_SRA:  alu_y = $unsigned($signed(bus.a) >>> shamt);
      default: alu_y = '0;
    endcase
  end

  // One iteration. MUL: acc=product, sh=multiplier, opnd=multiplicand.
  // DIV: acc=partial remainder, sh=dividend shifting out / quotient shifting in, opnd=divisor.
  // A zero divisor never restores, so the quotient fills with ones and the remainder ends as a.
  always_comb begin
    acc_nxt  = acc;
    sh_nxt   = sh;
    opnd_nxt = opnd;
    div_sh   = {acc, sh[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, opnd};
    if (op_r == OP_MUL) begin
      if (sh[0]) acc_nxt = acc + opnd;
      opnd_nxt = opnd << 1;
      sh_nxt   = sh >> 1;
    end else if (div_ge) begin
      acc_nxt = div_sh[WIDTH-1:0] - opnd;
      sh_nxt  = {sh[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = div_sh[WIDTH-1:0];
      sh_nxt  = {sh[WIDTH-2:0], 1'b0};
    end
    iter_y = (op_r == OP_DIVU) ? sh_nxt : acc_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = is_iter ? BUSY : DONE;
      BUSY:    if (cnt == CW'(1)) state_nxt = DONE;
      DONE: begin
        if (accept)             state_nxt = is_iter ? BUSY : DONE;
        else if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r   <= '0;
      acc    <= '0;
      sh     <= '0;
      opnd   <= '0;
      cnt    <= '0;
      y_r    <= '0;
      zero_r <= 1'b0;
    end else if (accept) begin
      op_r <= bus.op;
      cnt  <= CW'(WIDTH);
      acc  <= '0;
      sh   <= (bus.op == OP_MUL) ? bus.b : bus.a;
      opnd <= (bus.op == OP_MUL) ? bus.a : bus.b;
      if (!is_iter) begin
        y_r    <= alu_y;
        zero_r <= (alu_y == '0);
      end
    end else if (state == BUSY) begin
      acc  <= acc_nxt;
      sh   <= sh_nxt;
      opnd <= opnd_nxt;
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        y_r    <= iter_y;
        zero_r <= (iter_y == '0);
      end
    end
  end
endmodule

// File: tb/tb_cpu4_alu_mc.sv
// Scoreboard bench for cpu4_alu_mc: a 32-bit instance with MUL/DIV and an 8-bit one without.
module tb_cpu4_alu_mc;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu4_alu_mc_if #(.WIDTH(32)) bus32 ();
  cpu4_alu_mc_if #(.WIDTH(8))  bus8 ();

  cpu4_alu_mc #(.WIDTH(32), .MULDIV_EN(1'b1)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  cpu4_alu_mc #(.WIDTH(8),  .MULDIV_EN(1'b0)) dut8  (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct {
    logic [31:0] y;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model written from the opcode table using native operators.
  function automatic logic [31:0] ref32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return $unsigned($signed(a) >>> b[4:0]);
      4'd10: return p[31:0];
      4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bus32.in_valid = 1'b1;
    bus32.op = op; bus32.a = a; bus32.b = b;
    e.y = ref32(op, a, b);
    e.zero = (e.y == 32'd0);
    sb.push_back(e);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; bus32.op = '0; bus32.a = '0; bus32.b = '0;
    bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b1; bus8.op  = '0; bus8.a  = '0; bus8.b  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_chk++; if (bus32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus32.out_valid); end
    n_chk++; if (bus32.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus32.busy); end
    n_chk++; if (bus32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus32.in_ready); end
    n_chk++; if (bus32.y !== 32'd0 || bus32.zero !== 1'b0) begin n_fail++; $display("FAIL reset_y got %h/%b want 0/0", bus32.y, bus32.zero); end
    n_chk++; if (bus8.out_valid !== 1'b0 || bus8.y !== 8'd0) begin n_fail++; $display("FAIL reset8 got %b/%h want 0/00", bus8.out_valid, bus8.y); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  ops[5] = '{4'd0, 4'd1, 4'd9, 4'd5, 4'd6};
    logic [31:0] as[5]  = '{32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs[5]  = '{32'd1, 32'd5, 32'h24, 32'd1, 32'd1};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (bus32.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, bus32.in_ready); end
      issue32(ops[i], as[i], bs[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_chk++; if (bus32.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b want 1", i, bus32.out_valid); end
      n_chk++; if (bus32.y !== e.y) begin n_fail++; $display("FAIL b2b_y[%0d] got %h want %h", i, bus32.y, e.y); end
      n_chk++; if (bus32.zero !== e.zero) begin n_fail++; $display("FAIL b2b_zero[%0d] got %b want %b", i, bus32.zero, e.zero); end
    end
    bus32.in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (bus32.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", bus32.out_valid); end
  endtask

  task automatic test_muldiv;
    logic [3:0]  ops[5] = '{4'd10, 4'd11, 4'd12, 4'd11, 4'd12};
    logic [31:0] as[5]  = '{32'h0001_0001, 32'd100, 32'd100, 32'd9, 32'd9};
    logic [31:0] bs[5]  = '{32'h0001_0001, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] want[5] = '{32'h0002_0001, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
    exp_t e;
    int lat, busy_cnt;
    bit bad;
    for (int i = 0; i < 5; i++) begin
      issue32(ops[i], as[i], bs[i]);
      @(negedge clk);
      bus32.in_valid = 1'b0;
      lat = 1; busy_cnt = 0; bad = 1'b0;
      while (bus32.out_valid !== 1'b1 && lat < 200) begin
        if (bus32.busy === 1'b1) busy_cnt++;
        if (bus32.in_ready !== 1'b0) bad = 1'b1;
        @(negedge clk);
        lat++;
      end
      e = sb.pop_front();
      n_chk++; if (lat != 33) begin n_fail++; $display("FAIL md_latency[%0d] got %0d want 33", i, lat); end
      n_chk++; if (busy_cnt != 32) begin n_fail++; $display("FAIL md_busy_cycles[%0d] got %0d want 32", i, busy_cnt); end
      n_chk++; if (bad) begin n_fail++; $display("FAIL md_in_ready[%0d] got 1 during busy want 0", i); end
      n_chk++; if (bus32.y !== want[i] || bus32.y !== e.y) begin n_fail++; $display("FAIL md_y[%0d] got %h want %h", i, bus32.y, want[i]); end
      n_chk++; if (bus32.zero !== e.zero) begin n_fail++; $display("FAIL md_zero[%0d] got %b want %b", i, bus32.zero, e.zero); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    exp_t e;
    bus32.out_ready = 1'b0;
    issue32(4'd0, 32'd3, 32'd4);
    @(negedge clk);
    issue32(4'd4, 32'h0000_F0F0, 32'h0000_0FF0);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (bus32.out_valid !== 1'b1 || bus32.y !== e.y || bus32.y !== 32'd7) begin n_fail++; $display("FAIL bp_hold[%0d] got %b/%h want 1/00000007", i, bus32.out_valid, bus32.y); end
      n_chk++; if (bus32.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus32.in_ready); end
      @(negedge clk);
    end
    bus32.out_ready = 1'b1;
    #1;
    n_chk++; if (bus32.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", bus32.in_ready); end
    @(negedge clk);
    bus32.in_valid = 1'b0;
    e = sb.pop_front();
    n_chk++; if (bus32.out_valid !== 1'b1 || bus32.y !== e.y) begin n_fail++; $display("FAIL bp_next got %b/%h want 1/%h", bus32.out_valid, bus32.y, e.y); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_div;
    exp_t e;
    int lat;
    bus32.in_valid = 1'b1; bus32.op = 4'd11; bus32.a = 32'd1000; bus32.b = 32'd3;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_chk++; if (bus32.out_valid !== 1'b0 || bus32.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state got valid=%b busy=%b want 0/0", bus32.out_valid, bus32.busy); end
    n_chk++; if (bus32.in_ready !== 1'b1 || bus32.y !== 32'd0) begin n_fail++; $display("FAIL rst_mid_out got rdy=%b y=%h want 1/0", bus32.in_ready, bus32.y); end
    issue32(4'd0, 32'd1, 32'd1);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    lat = 1;
    while (bus32.out_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    e = sb.pop_front();
    n_chk++; if (lat != 1 || bus32.y !== e.y || bus32.y !== 32'd2) begin n_fail++; $display("FAIL rst_mid_add got lat=%0d y=%h want 1/00000002", lat, bus32.y); end
    @(negedge clk);
  endtask

  task automatic test_width8_nomuldiv;
    logic [3:0] ops[4] = '{4'd10, 4'd11, 4'd12, 4'd7};
    logic [7:0] as[4]  = '{8'h12, 8'h64, 8'h64, 8'h81};
    logic [7:0] bs[4]  = '{8'h34, 8'h07, 8'h07, 8'h0F};
    logic [7:0] want[4] = '{8'h00, 8'h00, 8'h00, 8'h80};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      bus8.in_valid = 1'b1; bus8.op = ops[i]; bus8.a = as[i]; bus8.b = bs[i];
      e.y = {24'd0, want[i]}; e.zero = (want[i] == 8'd0);
      sb.push_back(e);
      @(negedge clk);
      bus8.in_valid = 1'b0;
      e = sb.pop_front();
      n_chk++; if (bus8.out_valid !== 1'b1 || bus8.busy !== 1'b0) begin n_fail++; $display("FAIL w8_latency[%0d] got valid=%b busy=%b want 1/0", i, bus8.out_valid, bus8.busy); end
      n_chk++; if ({24'd0, bus8.y} !== e.y) begin n_fail++; $display("FAIL w8_y[%0d] got %h want %h", i, bus8.y, e.y[7:0]); end
      n_chk++; if (bus8.zero !== e.zero) begin n_fail++; $display("FAIL w8_zero[%0d] got %b want %b", i, bus8.zero, e.zero); end
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    exp_t e;
    int lat, want_lat;
    logic [3:0] op;
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 15));
      issue32(op, $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      want_lat = (op >= 4'd10 && op <= 4'd12) ? 33 : 1;
      @(negedge clk);
      bus32.in_valid = 1'b0;
      lat = 1;
      while (bus32.out_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      e = sb.pop_front();
      n_chk++; if (lat != want_lat || bus32.y !== e.y || bus32.zero !== e.zero) begin
        n_fail++;
        $display("FAIL rand[%0d] op=%0d got lat=%0d y=%h z=%b want lat=%0d y=%h z=%b", i, op, lat, bus32.y, bus32.zero, want_lat, e.y, e.zero);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_muldiv();
    test_backpressure();
    test_reset_mid_div();
    test_width8_nomuldiv();
    test_random();
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
